hid_uart_decoder: RTL and testbench
===================================

Name: hid_uart_decoder

Overview:
- UART-side reader for a serialized HID report link. Receives 8N1 bytes on `uart_rx`, deframes fixed 11-byte report packets and validates the checksum.
- On a valid packet it presents the same decoded fields the USB HID host core produces: type, report strobe, keyboard, mouse and gamepad.
- Sits at the far end of a board-to-board or PC-to-FPGA serial link, so downstream logic can consume HID data without a local USB port.

Parameters:
- `CLK_HZ`, 12000000, clock frequency in Hz.
- `BAUD`, 115200, line rate. `CLKS_PER_BIT` = `CLK_HZ`/`BAUD` (integer division), 104 at defaults.
- `TIMEOUT_BITS`, 20, idle bit-times allowed between bytes inside a packet.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous active-low reset.
- `uart_rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `typ`  out  2  0 none, 1 keyboard, 2 mouse, 3 gamepad.
- `report`  out  1  one-cycle pulse per accepted packet.
- `key_modifiers`, `key1`, `key2`, `key3`, `key4`  out  8 each  keyboard fields.
- `mouse_btn`  out  8  mouse buttons.
- `mouse_dx`, `mouse_dy`  out  8 each  signed mouse deltas.
- `game_btn`  out  10  {sta, sel, y, x, b, a, d, u, r, l}, bit0 = l.
- `dbg_report`  out  64  raw payload of the last accepted packet, byte0 in [7:0].
- `frm_err`  out  1  one-cycle pulse on stop-bit failure.
- `sum_err`  out  1  one-cycle pulse on checksum mismatch.

Behaviour:
- Reset: every output is 0 and `typ` = 0. Receiver is idle and the parser is in HUNT.
- Reset can assert at any point, including mid-byte or mid-packet. A partial byte or packet is discarded and no pulse fires.

Byte receiver:
- `uart_rx` passes through a 2-flop synchronizer, reset value 1.
- IDLE: a sampled falling edge starts the bit counter.
- At `CLKS_PER_BIT`/2 the start bit is rechecked. If it reads high, treat it as a glitch and return to IDLE.
- Data bits are then sampled every `CLKS_PER_BIT`, 8 bits, LSB first, followed by the stop bit.
- Stop bit = 1: internal `byte_valid` pulses on the stop-sample cycle.
- Stop bit = 0: `frm_err` pulses, the byte is dropped, and the receiver waits for the line to return high before re-arming.

Packet format:
- Byte order: `0xA5`, TYPE, P0..P7, CSUM.
- CSUM = TYPE ^ P0 ^ … ^ P7.

Parser FSM:
- HUNT: waits for a byte equal to `0xA5`. Any other byte is ignored.
- TYPE: byte values 1..3 are stored and the FSM goes to PAYLOAD. Any other value returns to HUNT silently. `0xA5` received here stays in TYPE, treated as a resync.
- PAYLOAD: stores 8 bytes using a 3-bit index and goes to CSUM after P7.
- CSUM on match, on the cycle after `byte_valid`:
  - `report` = 1 for one cycle.
  - `typ`, `dbg_report` and the field set for that type update on the same cycle.
  - Fields of the other types hold their previous values.
  - FSM returns to HUNT.
- CSUM on mismatch: `sum_err` pulses for one cycle, no outputs change, FSM returns to HUNT.
- `frm_err` in any non-HUNT state aborts to HUNT.
- Timeout: outside HUNT, an idle gap of `TIMEOUT_BITS`*`CLKS_PER_BIT` clocks since the last `byte_valid` aborts to HUNT with no pulse. The counter saturates.

Field mapping:
- Keyboard: P0 = `key_modifiers`, P1 reserved, P2..P5 = `key1`..`key4`.
- Mouse: P0 = `mouse_btn`, P1 = `mouse_dx`, P2 = `mouse_dy`.
- Gamepad: P0[7:0] = `game_btn`[7:0], P1[1:0] = `game_btn`[9:8].

Timing and pulses:
- Latency from the checksum stop-bit sample to `report` is exactly 1 clock.
- `report` and `sum_err` never assert on the same cycle.
- Back-to-back packets with zero inter-byte gap must be accepted with no loss.

Test Plan:
- Reset, then idle line: all outputs 0, no pulses for 10000 cycles.
- Keyboard packet A5 01 02 00 04 05 00 00 00 00, CSUM 0x02: one `report` pulse, `typ`=1, `key_modifiers`=0x02, `key1`=0x04, `key2`=0x05, `key3`=`key4`=0, `dbg_report`=0x0000_0000_0504_0002.
- Mouse packet A5 02 01 FB 03 00 00 00 00 00, CSUM 0xFB: `typ`=2, `mouse_btn`=1, `mouse_dx`=-5, `mouse_dy`=3, keyboard fields unchanged from the previous test.
- Mouse packet with CSUM 0x00: `sum_err` pulse, no `report`, all fields hold. A following valid gamepad packet A5 03 11 02 00 00 00 00 00 00, CSUM 0x10, then gives `typ`=3 and `game_btn`=0x211.
- Stop bit forced 0 on P3 of a keyboard packet: `frm_err` pulse, no `report`. The remaining bytes are ignored until the next `0xA5`, and the next valid packet is accepted.
- Send A5 01 plus 3 payload bytes, stall 25 bit-times, then a full valid packet: no pulse from the stalled fragment, exactly one `report` for the full packet.
- `resetn` low mid-payload, then a valid packet: outputs 0 after reset, and the packet decodes correctly.

Source files
------------

// File: rtl/hid_uart_decoder.sv
// hid_uart_decoder
//   UART-side reader for a serialized HID report link. An 8N1 byte
//   receiver feeds a packet parser that deframes 11-byte packets
//   (A5, TYPE, P0..P7, CSUM) and publishes decoded HID fields when the
//   XOR checksum matches.
//
// Ports
//   clk            system clock
//   resetn         asynchronous active-low reset
//   uart_rx        serial input, idle high, asynchronous to clk
//   typ            0 none, 1 keyboard, 2 mouse, 3 gamepad
//   report         one-cycle pulse per accepted packet
//   key_modifiers, key1..key4      keyboard fields
//   mouse_btn, mouse_dx, mouse_dy  mouse fields (deltas signed)
//   game_btn       {sta, sel, y, x, b, a, d, u, r, l}, bit0 = l
//   dbg_report     raw payload of last accepted packet, byte0 in [7:0]
//   frm_err        one-cycle pulse on stop-bit failure
//   sum_err        one-cycle pulse on checksum mismatch
//   dbg_state      {receiver state, parser state} for observation
//
// Handshake: the receiver hands bytes to the parser with byte_valid, a
// single-cycle strobe with rx_byte valid on that same cycle. The parser
// has no back-pressure; it always consumes a byte in the cycle it arrives.
module hid_uart_decoder #(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rx,
  output logic [1:0]  typ,
  output logic        report,
  output logic [7:0]  key_modifiers,
  output logic [7:0]  key1,
  output logic [7:0]  key2,
  output logic [7:0]  key3,
  output logic [7:0]  key4,
  output logic [7:0]  mouse_btn,
  output logic [7:0]  mouse_dx,
  output logic [7:0]  mouse_dy,
  output logic [9:0]  game_btn,
  output logic [63:0] dbg_report,
  output logic        frm_err,
  output logic        sum_err,
  output logic [5:0]  dbg_state
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TO_CLKS      = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W         = $clog2(TO_CLKS + 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    P_HUNT, P_TYPE, P_PAYLOAD, P_CSUM
  } prs_state_t;

  // ---------------------------------------------------------------
  // Input synchronizer; rx_d is one more stage for edge detection.
  // ---------------------------------------------------------------
  logic rx_meta, rx_s, rx_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // ---------------------------------------------------------------
  // Byte receiver
  // ---------------------------------------------------------------
  rx_state_t        rx_state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;

  wire stop_sample = (rx_state == RX_STOP) && (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  // byte_valid and frm_det fire on the stop-sample cycle itself so the
  // parser's registered outputs land exactly one clock later.
  wire       byte_valid = stop_sample && rx_s;
  wire       frm_det    = stop_sample && !rx_s;
  wire [7:0] rx_byte    = rx_shift;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
      frm_err  <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          clk_cnt <= '0;
          if (rx_d && !rx_s) rx_state <= RX_START;
        end
        RX_START: begin
          if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            // A start bit that is already high again was a glitch.
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            clk_cnt  <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};  // LSB first
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (stop_sample) begin
            clk_cnt <= '0;
            if (rx_s) begin
              rx_state <= RX_IDLE;
            end else begin
              frm_err  <= 1'b1;
              rx_state <= RX_WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          // Do not re-arm on a line stuck low after a bad stop bit.
          if (rx_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Packet parser
  // ---------------------------------------------------------------
  prs_state_t      prs_state;
  logic [1:0]      typ_lat;
  logic [2:0]      pay_idx;
  logic [63:0]     payload;
  logic [7:0]      csum_acc;
  logic [TO_W-1:0] to_cnt;

  wire timed_out = (to_cnt == TO_W'(TO_CLKS));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prs_state     <= P_HUNT;
      typ_lat       <= '0;
      pay_idx       <= '0;
      payload       <= '0;
      csum_acc      <= '0;
      to_cnt        <= '0;
      typ           <= '0;
      report        <= 1'b0;
      sum_err       <= 1'b0;
      key_modifiers <= '0;
      key1          <= '0;
      key2          <= '0;
      key3          <= '0;
      key4          <= '0;
      mouse_btn     <= '0;
      mouse_dx      <= '0;
      mouse_dy      <= '0;
      game_btn      <= '0;
      dbg_report    <= '0;
    end else begin
      report  <= 1'b0;
      sum_err <= 1'b0;

      // Inter-byte idle counter, saturating, cleared by each new byte.
      if (prs_state == P_HUNT || byte_valid) to_cnt <= '0;
      else if (!timed_out)                   to_cnt <= to_cnt + 1'b1;

      if (prs_state != P_HUNT && (frm_det || timed_out)) begin
        prs_state <= P_HUNT;
      end else if (byte_valid) begin
        case (prs_state)
          P_HUNT: begin
            if (rx_byte == SYNC_BYTE) prs_state <= P_TYPE;
          end
          P_TYPE: begin
            if (rx_byte == SYNC_BYTE) begin
              prs_state <= P_TYPE;  // resync on a repeated sync byte
            end else if (rx_byte >= 8'd1 && rx_byte <= 8'd3) begin
              typ_lat   <= rx_byte[1:0];
              csum_acc  <= rx_byte;
              pay_idx   <= '0;
              prs_state <= P_PAYLOAD;
            end else begin
              prs_state <= P_HUNT;
            end
          end
          P_PAYLOAD: begin
            // Shift in from the top so P0 ends up in payload[7:0].
            payload  <= {rx_byte, payload[63:8]};
            csum_acc <= csum_acc ^ rx_byte;
            pay_idx  <= pay_idx + 1'b1;
            if (pay_idx == 3'd7) prs_state <= P_CSUM;
          end
          P_CSUM: begin
            prs_state <= P_HUNT;
            if (rx_byte == csum_acc) begin
              report     <= 1'b1;
              typ        <= typ_lat;
              dbg_report <= payload;
              case (typ_lat)
                2'd1: begin
                  key_modifiers <= payload[7:0];
                  key1          <= payload[23:16];
                  key2          <= payload[31:24];
                  key3          <= payload[39:32];
                  key4          <= payload[47:40];
                end
                2'd2: begin
                  mouse_btn <= payload[7:0];
                  mouse_dx  <= payload[15:8];
                  mouse_dy  <= payload[23:16];
                end
                2'd3: begin
                  game_btn <= {payload[9:8], payload[7:0]};
                end
                default: ;
              endcase
            end else begin
              sum_err <= 1'b1;
            end
          end
          default: prs_state <= P_HUNT;
        endcase
      end
    end
  end

  assign dbg_state = {rx_state, prs_state};

endmodule

// File: tb/tb_hid_uart_decoder.sv
module tb_hid_uart_decoder;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;  // 16 clocks per bit

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic uart_rx = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  typ;
  logic        report, frm_err, sum_err;
  logic [7:0]  key_modifiers, key1, key2, key3, key4;
  logic [7:0]  mouse_btn, mouse_dx, mouse_dy;
  logic [9:0]  game_btn;
  logic [63:0] dbg_report;
  logic [5:0]  dbg_state;

  hid_uart_decoder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .resetn(resetn), .uart_rx(uart_rx),
    .typ(typ), .report(report),
    .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
    .mouse_btn(mouse_btn), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
    .game_btn(game_btn), .dbg_report(dbg_report),
    .frm_err(frm_err), .sum_err(sum_err), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Pulse monitors: count cycles each pulse is high, sampled mid-cycle.
  int n_report = 0, n_sum = 0, n_frm = 0, n_both = 0;
  always @(negedge clk) begin
    if (report === 1'b1) n_report++;
    if (sum_err === 1'b1) n_sum++;
    if (frm_err === 1'b1) n_frm++;
    if (report === 1'b1 && sum_err === 1'b1) n_both++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle_bits(input int nbits);
    uart_rx = 1'b1;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    if (!stop) idle_bits(1);  // let the line return high after a bad stop bit
    uart_rx = 1'b1;
  endtask

  // pay holds P0 in [7:0] .. P7 in [63:56]; cs is hand-computed.
  task automatic send_pkt(input logic [7:0] t, input logic [63:0] pay, input logic [7:0] cs);
    send_byte(8'hA5, 1'b1);
    send_byte(t, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(pay[8*i +: 8], 1'b1);
    send_byte(cs, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int r0, s0, f0;
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({typ, report, frm_err, sum_err, dbg_report} !== 69'd0) begin
      n_err++; $display("FAIL reset_outputs: got typ=%0d rep=%b frm=%b sum=%b dbg=%h, want all 0",
                        typ, report, frm_err, sum_err, dbg_report);
    end
    resetn = 1'b1;
    r0 = n_report; s0 = n_sum; f0 = n_frm;
    repeat (10000) @(negedge clk);
    n_cmp++;
    if ((n_report - r0) + (n_sum - s0) + (n_frm - f0) !== 0) begin
      n_err++; $display("FAIL idle_pulses: got %0d pulses, want 0", (n_report - r0) + (n_sum - s0) + (n_frm - f0));
    end
    n_cmp++;
    if ({key_modifiers, key1, key2, key3, key4, mouse_btn, mouse_dx, mouse_dy, game_btn, typ} !== 76'd0) begin
      n_err++; $display("FAIL idle_fields: got nonzero field, want all 0");
    end
  endtask

  task automatic test_keyboard;
    int r0 = n_report;
    send_pkt(8'h01, 64'h0000_0000_0504_0002, 8'h02);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_report - r0 !== 1) begin n_err++; $display("FAIL kbd_report: got %0d pulse cycles, want 1", n_report - r0); end
    n_cmp++;
    if (typ !== 2'd1) begin n_err++; $display("FAIL kbd_typ: got %0d, want 1", typ); end
    n_cmp++;
    if ({key_modifiers, key1, key2, key3, key4} !== 40'h02_04_05_00_00) begin
      n_err++; $display("FAIL kbd_keys: got %h %h %h %h %h, want 02 04 05 00 00",
                        key_modifiers, key1, key2, key3, key4);
    end
    n_cmp++;
    if (dbg_report !== 64'h0000_0000_0504_0002) begin
      n_err++; $display("FAIL kbd_dbg: got %h, want 0000000005040002", dbg_report);
    end
  endtask

  task automatic test_mouse;
    int r0 = n_report;
    send_pkt(8'h02, 64'h0000_0000_0003_FB01, 8'hFB);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_report - r0 !== 1) begin n_err++; $display("FAIL mouse_report: got %0d, want 1", n_report - r0); end
    n_cmp++;
    if (typ !== 2'd2) begin n_err++; $display("FAIL mouse_typ: got %0d, want 2", typ); end
    n_cmp++;
    if ({mouse_btn, mouse_dx, mouse_dy} !== 24'h01_FB_03) begin
      n_err++; $display("FAIL mouse_fields: got %h %h %h, want 01 fb 03", mouse_btn, mouse_dx, mouse_dy);
    end
    n_cmp++;
    if ({key_modifiers, key1, key2} !== 24'h02_04_05) begin
      n_err++; $display("FAIL mouse_kbd_hold: got %h %h %h, want 02 04 05", key_modifiers, key1, key2);
    end
  endtask

  task automatic test_bad_csum;
    int r0 = n_report, s0 = n_sum;
    send_pkt(8'h02, 64'h0000_0000_0003_FB01, 8'h00);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_sum - s0 !== 1 || n_report - r0 !== 0) begin
      n_err++; $display("FAIL csum_pulses: got sum_err=%0d report=%0d, want 1 0", n_sum - s0, n_report - r0);
    end
    n_cmp++;
    if (typ !== 2'd2 || mouse_dx !== 8'hFB || dbg_report !== 64'h0000_0000_0003_FB01) begin
      n_err++; $display("FAIL csum_hold: got typ=%0d dx=%h dbg=%h, want 2 fb 000000000003fb01", typ, mouse_dx, dbg_report);
    end
    r0 = n_report;
    send_pkt(8'h03, 64'h0000_0000_0000_0211, 8'h10);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_report - r0 !== 1 || typ !== 2'd3 || game_btn !== 10'h211) begin
      n_err++; $display("FAIL gamepad: got rep=%0d typ=%0d btn=%h, want 1 3 211", n_report - r0, typ, game_btn);
    end
  endtask

  task automatic test_frame_error;
    int r0 = n_report, f0 = n_frm, s0 = n_sum;
    logic [7:0] frag [0:10];
    frag = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    for (int i = 0; i < 11; i++) send_byte(frag[i], (i == 5) ? 1'b0 : 1'b1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_frm - f0 !== 1 || n_report - r0 !== 0 || n_sum - s0 !== 0) begin
      n_err++; $display("FAIL frm_pulses: got frm=%0d rep=%0d sum=%0d, want 1 0 0", n_frm - f0, n_report - r0, n_sum - s0);
    end
    send_pkt(8'h01, 64'h0000_4433_2211_0000, 8'h45);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_report - r0 !== 1 || {key_modifiers, key1, key2, key3, key4} !== 40'h00_11_22_33_44) begin
      n_err++; $display("FAIL frm_recover: got rep=%0d keys=%h %h %h %h %h, want 1 00 11 22 33 44",
                        n_report - r0, key_modifiers, key1, key2, key3, key4);
    end
  endtask

  task automatic test_timeout;
    int r0 = n_report, s0 = n_sum;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    idle_bits(25);
    n_cmp++;
    if (n_report - r0 !== 0) begin n_err++; $display("FAIL timeout_frag: got %0d reports, want 0", n_report - r0); end
    send_pkt(8'h02, 64'h0000_0000_00F0_1007, 8'hE5);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_report - r0 !== 1 || n_sum - s0 !== 0) begin
      n_err++; $display("FAIL timeout_pulses: got rep=%0d sum=%0d, want 1 0", n_report - r0, n_sum - s0);
    end
    n_cmp++;
    if ({mouse_btn, mouse_dx, mouse_dy} !== 24'h07_10_F0) begin
      n_err++; $display("FAIL timeout_fields: got %h %h %h, want 07 10 f0", mouse_btn, mouse_dx, mouse_dy);
    end
  endtask

  task automatic test_back_to_back;
    int r0 = n_report, s0 = n_sum, f0 = n_frm;
    send_pkt(8'h01, 64'h0000_0000_000A_0080, 8'h8B);
    send_pkt(8'h02, 64'h0000_0000_00FF_0102, 8'hFE);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_report - r0 !== 2 || n_sum - s0 !== 0 || n_frm - f0 !== 0) begin
      n_err++; $display("FAIL b2b_pulses: got rep=%0d sum=%0d frm=%0d, want 2 0 0", n_report - r0, n_sum - s0, n_frm - f0);
    end
    n_cmp++;
    if (typ !== 2'd2 || key_modifiers !== 8'h80 || key1 !== 8'h0A || mouse_dy !== 8'hFF || mouse_dx !== 8'h01) begin
      n_err++; $display("FAIL b2b_fields: got typ=%0d mod=%h k1=%h dx=%h dy=%h, want 2 80 0a 01 ff",
                        typ, key_modifiers, key1, mouse_dx, mouse_dy);
    end
  endtask

  task automatic test_reset_mid_packet;
    int r0, s0, f0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h33, 1'b1);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    r0 = n_report; s0 = n_sum; f0 = n_frm;
    resetn = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({typ, key_modifiers, key1, mouse_btn, mouse_dx, mouse_dy, game_btn, dbg_report} !== 116'd0) begin
      n_err++; $display("FAIL midrst_outputs: got typ=%0d mod=%h dx=%h btn=%h dbg=%h, want all 0",
                        typ, key_modifiers, mouse_dx, game_btn, dbg_report);
    end
    uart_rx = 1'b1;
    resetn = 1'b1;
    idle_bits(4);
    send_pkt(8'h03, 64'h0000_0000_0000_0211, 8'h10);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_report - r0 !== 1 || n_sum - s0 !== 0 || n_frm - f0 !== 0) begin
      n_err++; $display("FAIL midrst_pulses: got rep=%0d sum=%0d frm=%0d, want 1 0 0", n_report - r0, n_sum - s0, n_frm - f0);
    end
    n_cmp++;
    if (typ !== 2'd3 || game_btn !== 10'h211 || key_modifiers !== 8'h00 || dbg_report !== 64'h211) begin
      n_err++; $display("FAIL midrst_decode: got typ=%0d btn=%h mod=%h dbg=%h, want 3 211 00 0000000000000211",
                        typ, game_btn, key_modifiers, dbg_report);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_keyboard();
    test_mouse();
    test_bad_csum();
    test_frame_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_packet();
    n_cmp++;
    if (n_both !== 0) begin n_err++; $display("FAIL report_sum_overlap: got %0d cycles, want 0", n_both); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
